// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Holds the arbiter FSM state enum and default parameter values.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    GAP
  } state_t;

  localparam int DATA_BITS_DEF   = 8;
  localparam int TIMEOUT_CYC_DEF = 1023;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set req at or above ptr, wrapping.
// Ports: req, ptr in; valid, onehot, idx (winner) out.
module uart_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic            valid,
  output logic [NREQ-1:0] onehot,
  output logic [2:0]      idx
);

  int j;

  // Walk from the farthest candidate down to ptr itself so the
  // last assignment made is the closest requester at/after ptr.
  always_comb begin
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
    j      = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        valid  = 1'b1;
        idx    = 3'(j);
        onehot = NREQ'(1) << j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte sources.
// Ports: bclk, rst_n, req, req_data in; gnt, done, tx_start, tx_data,
// busy, owner out; tx_done in. Optional watchdog with macro
// UART_TX_ARB_TIMEOUT_EN adds sticky output timeout_err.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                      bclk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DATA_BITS-1:0] req_data,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic                      tx_start,
  output logic [DATA_BITS-1:0]      tx_data,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [2:0]                owner
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  output logic                      timeout_err
`endif
);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_cfg_err
    $error("uart_tx_arbiter: parameter out of range");
  end

  state_t state, state_n;
  logic [2:0]           ptr, ptr_n;
  logic [2:0]           owner_n;
  logic [DATA_BITS-1:0] tx_data_n;
  logic [NREQ-1:0]      gnt_n, done_n;
  logic                 tx_start_n;
  logic                 tx_done_q;
  logic                 rise;

  logic            pk_valid;
  logic [NREQ-1:0] pk_oh;
  logic [2:0]      pk_idx;

  uart_rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .valid  (pk_valid),
    .onehot (pk_oh),
    .idx    (pk_idx)
  );

  assign rise = tx_done & ~tx_done_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt, cnt_n;
  logic          terr_n;
`endif

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    owner_n    = owner;
    tx_data_n  = tx_data;
    gnt_n      = '0;
    done_n     = '0;
    tx_start_n = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_n      = '0;
    terr_n     = timeout_err;
`endif
    unique case (state)
      IDLE: begin
        if (pk_valid) begin
          owner_n   = pk_idx;
          tx_data_n = req_data[pk_idx*DATA_BITS +: DATA_BITS];
          gnt_n     = pk_oh;
          state_n   = START;
        end
      end
      START: begin
        tx_start_n = 1'b1;
        state_n    = WAIT;
      end
      WAIT: begin
        if (rise) begin
          done_n  = NREQ'(1) << owner;
          state_n = GAP;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          done_n  = NREQ'(1) << owner;
          terr_n  = 1'b1;
          state_n = GAP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
`endif
      end
      GAP: begin
        ptr_n   = (owner == 3'(NREQ - 1)) ? 3'd0 : owner + 3'd1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      tx_data   <= '0;
      gnt       <= '0;
      done      <= '0;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      owner     <= owner_n;
      tx_data   <= tx_data_n;
      gnt       <= gnt_n;
      done      <= done_n;
      tx_start  <= tx_start_n;
      busy      <= (state_n != IDLE);
      tx_done_q <= tx_done;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt         <= cnt_n;
      timeout_err <= terr_n;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter.
// Define UART_TX_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DB   = 8;

  logic            bclk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*DB-1:0] req_data = 32'h44_33_22_11;
  logic [NREQ-1:0] gnt, done;
  logic            tx_start;
  logic [DB-1:0]   tx_data;
  logic            tx_done = 1'b0;
  logic            busy;
  logic [2:0]      owner;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic            timeout_err;
`endif

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(
    .NREQ        (NREQ),
    .DATA_BITS   (DB),
    .TIMEOUT_CYC (16)
  ) dut (
    .bclk     (bclk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .busy     (busy),
    .owner    (owner)
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 bclk = ~bclk;

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge bclk);
      #1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick();
  endtask

  // One complete transaction with req held by the caller.
  task automatic xact(int who, string tag);
    tick();
    chk({tag, ".gnt"}, gnt, 32'(1 << who));
    chk({tag, ".owner"}, owner, who);
    chk({tag, ".data"}, tx_data, 8'h11 * (who + 1));
    chk({tag, ".busy"}, busy, 1);
    tick();
    chk({tag, ".start"}, tx_start, 1);
    chk({tag, ".gnt0"}, gnt, 0);
    tick();
    chk({tag, ".start0"}, tx_start, 0);
    tx_done = 1'b1;
    tick();
    chk({tag, ".done"}, done, 32'(1 << who));
    tx_done = 1'b0;
    tick();
    chk({tag, ".done0"}, done, 0);
    chk({tag, ".idle"}, busy, 0);
  endtask

  initial begin
    // reset state
    #2;
    chk("rst.gnt", gnt, 0);
    chk("rst.done", done, 0);
    chk("rst.start", tx_start, 0);
    chk("rst.busy", busy, 0);
    chk("rst.owner", owner, 0);
    chk("rst.data", tx_data, 0);
    do_reset();

    // idle with no requests
    tick(3);
    chk("idle.gnt", gnt, 0);
    chk("idle.busy", busy, 0);
    chk("idle.start", tx_start, 0);

    // single requester, 90-cycle transmission
    req_data[7:0] = 8'h55;
    req = 4'b0001;
    tick();
    chk("single.gnt", gnt, 4'b0001);
    chk("single.data", tx_data, 8'h55);
    req = 4'b0000;
    tick();
    chk("single.start", tx_start, 1);
    tick(89);
    chk("single.nodone", done, 0);
    chk("single.stable", tx_data, 8'h55);
    tx_done = 1'b1;
    tick();
    chk("single.done", done, 4'b0001);
    tx_done = 1'b0;
    tick();
    chk("single.idle", busy, 0);
    req_data[7:0] = 8'h11;

    // all four continuously: order 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    xact(0, "rr0");
    xact(1, "rr1");
    xact(2, "rr2");
    xact(3, "rr3");
    xact(0, "rr4");
    req = 4'b0000;

    // stale tx_done level on entry to WAIT
    req = 4'b0001;
    tick();
    chk("stale.gnt", gnt, 4'b0001);
    tx_done = 1'b1;
    req = 4'b0000;
    tick();
    chk("stale.start", tx_start, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stale.nodone", done, 0);
    end
    tx_done = 1'b0;
    tick();
    chk("stale.nodone2", done, 0);
    tx_done = 1'b1;
    tick();
    chk("stale.done", done, 4'b0001);
    tx_done = 1'b0;
    tick();
    chk("stale.idle", busy, 0);

    // short req[2] pulse during WAIT is never granted
    req = 4'b0001;
    tick();
    chk("pulse.gnt", gnt, 4'b0001);
    req = 4'b0000;
    tick(2);
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    tx_done = 1'b1;
    tick();
    chk("pulse.done", done, 4'b0001);
    tx_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pulse.nognt", gnt, 0);
    end
    chk("pulse.idle", busy, 0);

    // reset in the middle of WAIT
    req = 4'b0010;
    tick();
    chk("mid.gnt", gnt, 4'b0010);
    chk("mid.owner", owner, 1);
    req = 4'b0000;
    tick();
    chk("mid.start", tx_start, 1);
    rst_n = 1'b0;
    #1;
    chk("mid.rst.start", tx_start, 0);
    chk("mid.rst.busy", busy, 0);
    chk("mid.rst.owner", owner, 0);
    chk("mid.rst.data", tx_data, 0);
    chk("mid.rst.gnt", gnt, 0);
    chk("mid.rst.done", done, 0);
    #2;
    rst_n = 1'b1;
    tx_done = 1'b1;
    tick(3);
    chk("mid.nodone", done, 0);
    tx_done = 1'b0;
    req = 4'b1001;
    tick();
    chk("mid.regnt", gnt, 4'b0001);
    req = 4'b0000;
    tick(2);
    tx_done = 1'b1;
    tick();
    chk("mid.done", done, 4'b0001);
    tx_done = 1'b0;
    tick();

`ifdef UART_TX_ARB_TIMEOUT_EN
    // watchdog with tx_done stuck low
    do_reset();
    req = 4'b0001;
    tick();
    chk("tmo.gnt", gnt, 4'b0001);
    req = 4'b0000;
    tick();
    chk("tmo.start", tx_start, 1);
    tick(15);
    chk("tmo.early", done, 0);
    chk("tmo.err0", timeout_err, 0);
    tick();
    chk("tmo.done", done, 4'b0001);
    chk("tmo.err1", timeout_err, 1);
    tick();
    chk("tmo.idle", busy, 0);
    req = 4'b0010;
    tick();
    chk("tmo.resume", gnt, 4'b0010);
    chk("tmo.sticky", timeout_err, 1);
    req = 4'b0000;
    tick(2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of byte requesters (2..8).
REQ-002 SHALL have parameter DATA_BITS, default 8, character width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1023, watchdog limit in bclk cycles.
REQ-004 SHALL have port bclk  in  1  clock; the same bit clock as the UART transmitter.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  in  NREQ  per-requester transmit request.
REQ-007 SHALL have port req_data  in  NREQ*DATA_BITS  per-requester character; requester i occupies bits [i*DATA_BITS +: DATA_BITS].
REQ-008 SHALL have port gnt  out  NREQ  one-hot, one-cycle pulse; signals that the character is accepted.
REQ-009 SHALL have port done  out  NREQ  one-hot, one-cycle pulse; signals that the owner's character has finished.
REQ-010 SHALL have port tx_start  out  1  drives the transmitter txd_startH.
REQ-011 SHALL have port tx_data  out  DATA_BITS  latched character to the transmitter.
REQ-012 SHALL have port tx_done  in  1  transmitter completion level (txd_done).
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.
REQ-014 SHALL have port owner  out  3  index of the current or last granted requester.

Function
REQ-015 SHALL implement FSM IDLE, START, WAIT, GAP; all outputs SHALL be registered.
REQ-016 IDLE: with any req high, SHALL select round-robin from pointer ptr upward with wrap at NREQ-1→0, latch tx_data and owner, pulse gnt[owner], then go to START.
REQ-017 IDLE with req==0 SHALL hold IDLE, with gnt, tx_start and done all 0.
REQ-018 START: SHALL assert tx_start for exactly 1 cycle, then go to WAIT.
REQ-019 WAIT: completion SHALL be a tx_done rising edge (high now, low in the previous cycle); on completion SHALL pulse done[owner] and go to GAP.
REQ-020 A tx_done edge in IDLE, START or GAP SHALL be ignored; the edge-detect register SHALL still update every cycle.
REQ-021 GAP: SHALL last 1 cycle, set ptr=(owner+1) mod NREQ, then go to IDLE.
REQ-022 Latency: req sampled in IDLE at cycle N → gnt at N+1, tx_start at N+2; after completion, next gnt no earlier than completion edge +3.
REQ-023 Requesters SHALL drop req in the cycle after gnt; a req still high on return to IDLE SHALL be treated as a new request.
REQ-024 A req deasserted before it is granted SHALL produce no gnt.
REQ-025 tx_data SHALL stay stable from gnt until exit from WAIT.
REQ-026 Simultaneous requests: exactly one gnt; every persistent requester SHALL be granted within NREQ transactions.

Reset
REQ-027 rst_n low SHALL force state=IDLE, ptr=0, owner=0, tx_data=0, and gnt, done, tx_start, busy all 0, regardless of state.
REQ-028 Reset mid-transmission SHALL drop tx_start immediately; the abandoned owner receives no done.

Configuration
REQ-029 With macro UART_TX_ARB_TIMEOUT_EN defined: a counter SHALL count cycles in WAIT.
REQ-030 When that counter reaches TIMEOUT_CYC: SHALL pulse done[owner], set sticky output timeout_err (cleared only by reset), and go to GAP.
REQ-031 Without UART_TX_ARB_TIMEOUT_EN: SHALL have no counter and no timeout_err port; WAIT is left only via tx_done.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state enum, the default DATA_BITS and the default TIMEOUT_CYC.
REQ-033 Sub-module uart_rr_pick SHALL be combinational: inputs req and ptr, outputs the valid flag and the one-hot/index of the winner.

Verification
REQ-034 Single requester: req=0001, data 0x55; tx_done rises 90 cycles after tx_start → gnt=0001 at N+1, tx_start at N+2, tx_data=0x55, done=0001.
REQ-035 All four requesting continuously → grant order 0,1,2,3,0 with ptr wrap; never two gnt bits set.
REQ-036 tx_done already high on entry to WAIT (stale level) → no done until the next rising edge.
REQ-037 rst_n pulsed low mid-WAIT → all outputs 0 within the reset cycle; busy=0; next grant starts from requester 0.
REQ-038 With UART_TX_ARB_TIMEOUT_EN defined and TIMEOUT_CYC=16, tx_done held 0 → done[owner] after 16 WAIT cycles, timeout_err=1, arbitration resumes.
REQ-039 req[2] pulsed 1 cycle during WAIT, then dropped → no gnt[2].
